aes_decrypt_byte_bridge: RTL and testbench



---
 rtl/aes_bridge_pkg.sv | 39 +++
 rtl/aes_block_serializer.sv | 63 ++++++
 rtl/aes_decrypt_byte_bridge.sv | 168 ++++++++++++++++
 tb/tb_aes_decrypt_byte_bridge.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_bridge_pkg.sv
// Shared state encoding, frame payload type and byte helpers for the AES decrypt byte bridge.
// Byte k of a 128-bit block lives at bits [127-8k -: 8].
package aes_bridge_pkg;

   localparam int unsigned BLOCK_BYTES = 16;
   localparam int unsigned CNT_W       = 4;
   localparam int unsigned BYTE_W      = 8;
   localparam int unsigned BLOCK_W     = BLOCK_BYTES * BYTE_W;

   typedef enum logic [2:0] {
      ST_RX_KEY    = 3'd0,
      ST_RX_CIPHER = 3'd1,
      ST_START     = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_TX        = 3'd4
   } state_e;

   typedef struct packed {
      logic [BLOCK_W-1:0] key;
      logic [BLOCK_W-1:0] cipher;
   } frame_t;

   function automatic logic [BYTE_W-1:0] byte_of(input logic [BLOCK_W-1:0] block,
                                                 input logic [CNT_W-1:0]   idx);
      logic [BLOCK_W-1:0] shifted;
      shifted = block << {idx, 3'b000};
      return shifted[BLOCK_W-1 -: BYTE_W];
   endfunction

   // Replace byte idx of block; (15-idx) is the bitwise inverse of a 4-bit index.
   function automatic logic [BLOCK_W-1:0] put_byte(input logic [BLOCK_W-1:0] block,
                                                   input logic [CNT_W-1:0]   idx,
                                                   input logic [BYTE_W-1:0]  b);
      logic [6:0] sh;
      sh = {~idx, 3'b000};
      return (block & ~(BLOCK_W'(8'hFF) << sh)) | (BLOCK_W'(b) << sh);
   endfunction

endpackage

// File: rtl/aes_block_serializer.sv
// Holds the decrypted block and streams it out MSB byte first over a valid/ready handshake.
module aes_block_serializer
   import aes_bridge_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_i,
   input  logic [BLOCK_W-1:0] block_i,
   input  logic               out_ready_i,
   output logic [BYTE_W-1:0]  out_byte_o,
   output logic               out_valid_o,
   output logic               last_accept_c_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_BYTES - 1);

   logic [BLOCK_W-1:0] result_q, result_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               out_valid_q, out_valid_d;
   logic [BYTE_W-1:0]  out_byte_q, out_byte_d;
   logic               accept_c;

   assign accept_c        = out_valid_q && out_ready_i;
   assign last_accept_c_o = accept_c && (cnt_q == CNT_LAST);

   always_comb begin
      result_d    = result_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_byte_d  = out_byte_q;
      if (load_i) begin
         result_d    = block_i;
         cnt_d       = '0;
         out_valid_d = 1'b1;
         out_byte_d  = byte_of(block_i, CNT_W'(0));
      end else if (accept_c) begin
         cnt_d = cnt_q + CNT_W'(1);
         if (cnt_q == CNT_LAST) begin
            out_valid_d = 1'b0;
         end else begin
            out_byte_d = byte_of(result_q, cnt_q + CNT_W'(1));
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q    <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_byte_q  <= '0;
      end else begin
         result_q    <= result_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_byte_q  <= out_byte_d;
      end
   end

   assign out_byte_o  = out_byte_q;
   assign out_valid_o = out_valid_q;

endmodule

// File: rtl/aes_decrypt_byte_bridge.sv
// Byte-stream bridge around the AES-128 decryptor: gathers key+cipher, runs one decrypt, returns plaintext.
// Optional KEY_REUSE_EN adds reuse_key so a frame may skip the key and reuse the last loaded one.
module aes_decrypt_byte_bridge
   import aes_bridge_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned TO_W           = 7
) (
   input  logic               clk,
   input  logic               rst,
`ifdef KEY_REUSE_EN
   input  logic               reuse_key,
`endif
   input  logic [BYTE_W-1:0]  in_byte,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [BYTE_W-1:0]  out_byte,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [BLOCK_W-1:0] chave,
   output logic [BLOCK_W-1:0] cifra,
   output logic               start,
   input  logic [BLOCK_W-1:0] palavra,
   input  logic               done,
   output logic               busy,
   output logic               timeout_err
);

   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_BYTES - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   frame_t           frame_q, frame_d;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
   logic             timeout_err_q, timeout_err_d;
   logic             in_ready_q;
   logic             busy_q;
   logic             start_q;
   logic             xfer_c;
   logic             reuse_c;
   logic             load_c;
   logic             tx_last_c;

   assign xfer_c = in_valid && in_ready_q;

`ifdef KEY_REUSE_EN
   logic key_loaded_q;
   logic key_done_c;

   assign reuse_c    = reuse_key && key_loaded_q && (cnt_q == '0);
   assign key_done_c = xfer_c && (state_q == ST_RX_KEY) && !reuse_c && (cnt_q == CNT_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         key_loaded_q <= 1'b0;
      end else if (key_done_c) begin
         key_loaded_q <= 1'b1;
      end
   end
`else
   assign reuse_c = 1'b0;
`endif

   // Next-state and frame assembly
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      frame_d       = frame_q;
      to_cnt_d      = to_cnt_q;
      timeout_err_d = timeout_err_q;
      load_c        = 1'b0;
      case (state_q)
         ST_RX_KEY: begin
            if (xfer_c) begin
               if (cnt_q == '0) timeout_err_d = 1'b0;
               if (reuse_c) begin
                  frame_d.cipher = put_byte(frame_q.cipher, CNT_W'(0), in_byte);
                  cnt_d          = CNT_W'(1);
                  state_d        = ST_RX_CIPHER;
               end else begin
                  frame_d.key = put_byte(frame_q.key, cnt_q, in_byte);
                  cnt_d       = cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_LAST) state_d = ST_RX_CIPHER;
               end
            end
         end
         ST_RX_CIPHER: begin
            if (xfer_c) begin
               frame_d.cipher = put_byte(frame_q.cipher, cnt_q, in_byte);
               cnt_d          = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_LAST) state_d = ST_START;
            end
         end
         ST_START: begin
            state_d  = ST_WAIT_DONE;
            to_cnt_d = '0;
            cnt_d    = '0;
         end
         ST_WAIT_DONE: begin
            // done on the final counted cycle still wins over the timeout
            if (done) begin
               load_c  = 1'b1;
               state_d = ST_TX;
               cnt_d   = '0;
            end else if (to_cnt_q == TO_LAST) begin
               timeout_err_d = 1'b1;
               state_d       = ST_RX_KEY;
               cnt_d         = '0;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end
         ST_TX: begin
            if (tx_last_c) begin
               state_d = ST_RX_KEY;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_RX_KEY;
            cnt_d   = '0;
         end
      endcase
   end

   // State and registered outputs, the latter decoded from the upcoming state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_RX_KEY;
         cnt_q         <= '0;
         frame_q       <= '0;
         to_cnt_q      <= '0;
         timeout_err_q <= 1'b0;
         in_ready_q    <= 1'b1;
         busy_q        <= 1'b0;
         start_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         frame_q       <= frame_d;
         to_cnt_q      <= to_cnt_d;
         timeout_err_q <= timeout_err_d;
         in_ready_q    <= (state_d == ST_RX_KEY) || (state_d == ST_RX_CIPHER);
         busy_q        <= (state_d == ST_START) || (state_d == ST_WAIT_DONE) || (state_d == ST_TX);
         start_q       <= (state_d == ST_START);
      end
   end

   aes_block_serializer u_serializer (
      .clk             (clk),
      .rst_n           (rst),
      .load_i          (load_c),
      .block_i         (palavra),
      .out_ready_i     (out_ready),
      .out_byte_o      (out_byte),
      .out_valid_o     (out_valid),
      .last_accept_c_o (tx_last_c)
   );

   assign in_ready    = in_ready_q;
   assign busy        = busy_q;
   assign start       = start_q;
   assign chave       = frame_q.key;
   assign cifra       = frame_q.cipher;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_aes_decrypt_byte_bridge.sv
// Directed/randomized bench for aes_decrypt_byte_bridge against a byte-list reference model.
// Define KEY_REUSE_EN to also exercise the key-reuse path.
module tb_aes_decrypt_byte_bridge;

   localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

   logic         clk;
   logic         rst;
   logic [7:0]   in_byte;
   logic         in_valid;
   logic         in_ready;
   logic [7:0]   out_byte;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] chave;
   logic [127:0] cifra;
   logic         start;
   logic [127:0] palavra;
   logic         done;
   logic         busy;
   logic         timeout_err;
`ifdef KEY_REUSE_EN
   logic         reuse_key;
`endif

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned n_start  = 0;
   int unsigned n_outv   = 0;

   aes_decrypt_byte_bridge #(.TIMEOUT_CYCLES(64), .TO_W(7)) dut (
      .clk         (clk),
      .rst         (rst),
`ifdef KEY_REUSE_EN
      .reuse_key   (reuse_key),
`endif
      .in_byte     (in_byte),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .out_byte    (out_byte),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .chave       (chave),
      .cifra       (cifra),
      .start       (start),
      .palavra     (palavra),
      .done        (done),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (start === 1'b1) n_start++;
      if (out_valid === 1'b1) n_outv++;
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: byte k of a block is the k-th most significant byte.
   function automatic logic [7:0] byte_k(input logic [127:0] blk, input int k);
      return 8'(blk >> (8 * (15 - k)));
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic send_byte(input logic [7:0] b, input int unsigned max_gap, output bit taken);
      int unsigned gap;
      gap   = (max_gap == 0) ? 0 : $urandom_range(max_gap, 0);
      taken = 1'b0;
      for (int unsigned i = 0; i < gap; i++) begin
         in_valid = 1'b0;
         in_byte  = 8'($urandom);
         tick();
      end
      in_valid = 1'b1;
      in_byte  = b;
      for (int i = 0; i < 200 && !taken; i++) begin
         taken = (in_ready === 1'b1);
         tick();
      end
      in_valid = 1'b0;
      in_byte  = 8'($urandom);
   endtask

   task automatic send_frame(input logic [127:0] key, input logic [127:0] cip,
                             input int unsigned max_gap, input int stray_at);
      int unsigned missed;
      bit          ok;
      missed = 0;
      for (int k = 0; k < 32; k++) begin
         send_byte((k < 16) ? byte_k(key, k) : byte_k(cip, k - 16), max_gap, ok);
         if (!ok) missed++;
         if (k == 0) check("terr_clear_first_byte", 128'(timeout_err), 128'(0));
         if (k == stray_at) begin
            done    = 1'b1;
            palavra = rand128();
            tick();
            done    = 1'b0;
            palavra = '0;
            check("stray_done_out_valid", 128'(out_valid), 128'(0));
            check("stray_done_in_ready", 128'(in_ready), 128'(1));
         end
      end
      check("in_bytes_lost", 128'(missed), 128'(0));
   endtask

   task automatic complete_frame(input logic [127:0] key, input logic [127:0] cip,
                                 input logic [127:0] pal, input int unsigned done_dly,
                                 input bit hold7);
      int unsigned s0;
      int unsigned bad;
      int          pos;
      bit          held;
      logic [7:0]  got [$];
      s0 = n_start;
      check("start_after_32nd", 128'(start), 128'(1));
      check("chave", chave, key);
      check("cifra", cifra, cip);
      check("busy_in_start", 128'(busy), 128'(1));
      check("in_ready_in_start", 128'(in_ready), 128'(0));
      in_valid = 1'b1;
      in_byte  = 8'hA5;
      bad      = 0;
      for (int unsigned c = 0; c < done_dly; c++) begin
         tick();
         if (in_ready !== 1'b0 || start !== 1'b0 || out_valid !== 1'b0) bad++;
      end
      check("wait_quiet", 128'(bad), 128'(0));
      in_valid = 1'b0;
      done     = 1'b1;
      palavra  = pal;
      tick();
      done     = 1'b0;
      palavra  = '0;
      check("start_once", 128'(n_start - s0), 128'(1));
      check("out_valid_after_done", 128'(out_valid), 128'(1));
      check("first_out_byte", 128'(out_byte), 128'(byte_k(pal, 0)));
      check("terr_after_done", 128'(timeout_err), 128'(0));
      pos  = 0;
      held = 1'b0;
      for (int c = 0; c < 500 && pos < 16; c++) begin
         if (hold7 && !held && pos == 7) begin
            out_ready = 1'b0;
            for (int h = 0; h < 5; h++) begin
               check("hold_byte7", 128'(out_byte), 128'(byte_k(pal, 7)));
               check("hold_valid", 128'(out_valid), 128'(1));
               tick();
            end
            held = 1'b1;
         end
         out_ready = ($urandom_range(3, 0) != 0);
         if (out_valid === 1'b1 && out_ready) begin
            got.push_back(out_byte);
            pos++;
         end
         tick();
      end
      out_ready = 1'b0;
      check("out_count", 128'(pos), 128'(16));
      foreach (got[k]) check($sformatf("out_byte%0d", k), 128'(got[k]), 128'(byte_k(pal, k)));
      check("out_valid_end", 128'(out_valid), 128'(0));
      check("busy_end", 128'(busy), 128'(0));
      check("in_ready_end", 128'(in_ready), 128'(1));
   endtask

   task automatic run_timeout(input logic [127:0] key, input logic [127:0] cip);
      int unsigned v0;
      int unsigned early;
      send_frame(key, cip, 1, -1);
      check("to_start", 128'(start), 128'(1));
      v0    = n_outv;
      early = 0;
      for (int c = 1; c <= 64; c++) begin
         tick();
         if (timeout_err !== 1'b0 || in_ready !== 1'b0) early++;
      end
      check("to_not_early", 128'(early), 128'(0));
      tick();
      check("to_err_set", 128'(timeout_err), 128'(1));
      check("to_in_ready", 128'(in_ready), 128'(1));
      check("to_busy", 128'(busy), 128'(0));
      check("to_out_valid_never", 128'(n_outv - v0), 128'(0));
   endtask

   initial begin
      logic [127:0] k_r;
      logic [127:0] c_r;
      logic [127:0] p_r;
      int unsigned  s0;
      int unsigned  missed;
      bit           ok;
      rst       = 1'b0;
      in_byte   = '0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      palavra   = '0;
      done      = 1'b0;
`ifdef KEY_REUSE_EN
      reuse_key = 1'b0;
`endif
      tick();
      tick();
      check("rst_in_ready", 128'(in_ready), 128'(1));
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_out_byte", 128'(out_byte), 128'(0));
      check("rst_start", 128'(start), 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_terr", 128'(timeout_err), 128'(0));
      check("rst_chave", chave, 128'(0));
      check("rst_cifra", cifra, 128'(0));
      rst = 1'b1;
      tick();

      // FIPS-197 vector, done 44 cycles after start
      send_frame(FIPS_KEY, FIPS_CT, 0, -1);
      complete_frame(FIPS_KEY, FIPS_CT, FIPS_PT, 44, 1'b0);

      // Back-pressure on both streams, output stalled at byte 7
      k_r = rand128();
      c_r = rand128();
      send_frame(k_r, c_r, 3, -1);
      complete_frame(k_r, c_r, FIPS_PT, $urandom_range(40, 2), 1'b1);

      // Stray done while receiving the cipher
      k_r = rand128();
      c_r = rand128();
      p_r = rand128();
      send_frame(k_r, c_r, 1, 20);
      complete_frame(k_r, c_r, p_r, 30, 1'b0);

      // Timeout, sticky error, then done on the last permitted cycle
      run_timeout(rand128(), rand128());
      tick();
      tick();
      check("terr_sticky", 128'(timeout_err), 128'(1));
      k_r = rand128();
      c_r = rand128();
      p_r = rand128();
      send_frame(k_r, c_r, 0, -1);
      complete_frame(k_r, c_r, p_r, 64, 1'b0);

      // Reset in the middle of a frame
      k_r = rand128();
      c_r = rand128();
      for (int k = 0; k < 20; k++) send_byte((k < 16) ? byte_k(k_r, k) : byte_k(c_r, k - 16), 2, ok);
      s0  = n_start;
      rst = 1'b0;
      #1;
      check("midrst_chave", chave, 128'(0));
      check("midrst_cifra", cifra, 128'(0));
      check("midrst_in_ready", 128'(in_ready), 128'(1));
      check("midrst_busy", 128'(busy), 128'(0));
      tick();
      tick();
      rst = 1'b1;
      tick();
      check("midrst_no_start", 128'(n_start - s0), 128'(0));
      k_r = rand128();
      c_r = rand128();
      p_r = rand128();
      send_frame(k_r, c_r, 2, -1);
      complete_frame(k_r, c_r, p_r, $urandom_range(60, 2), 1'b0);

      // Random frames
      for (int f = 0; f < 3; f++) begin
         k_r = rand128();
         c_r = rand128();
         p_r = rand128();
         send_frame(k_r, c_r, 2, -1);
         complete_frame(k_r, c_r, p_r, $urandom_range(64, 2), 1'b0);
      end

`ifdef KEY_REUSE_EN
      // reuse_key with no key loaded is just a key byte
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      k_r    = rand128();
      c_r    = rand128();
      p_r    = rand128();
      missed = 0;
      for (int k = 0; k < 16; k++) begin
         reuse_key = (k == 0);
         send_byte(byte_k(k_r, k), 0, ok);
         reuse_key = 1'b0;
         if (!ok) missed++;
      end
      check("reuse_unloaded_no_start", 128'(start), 128'(0));
      check("reuse_unloaded_in_ready", 128'(in_ready), 128'(1));
      check("reuse_unloaded_chave", chave, k_r);
      for (int k = 0; k < 16; k++) begin
         send_byte(byte_k(c_r, k), 0, ok);
         if (!ok) missed++;
      end
      complete_frame(k_r, c_r, p_r, 10, 1'b0);
      // Second frame carries only cipher bytes
      c_r = rand128();
      p_r = rand128();
      for (int k = 0; k < 16; k++) begin
         reuse_key = (k == 0);
         send_byte(byte_k(c_r, k), 1, ok);
         reuse_key = 1'b0;
         if (!ok) missed++;
      end
      check("reuse_bytes_lost", 128'(missed), 128'(0));
      complete_frame(k_r, c_r, p_r, 10, 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
